// File: rtl/ysyx_24110006_arb_pkg.sv
// Shared types and constants for the two-master AXI arbiter.
// Used by the picker and the arbiter top.
package ysyx_24110006_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_WR1  = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int         AXI_ID_W  = 4;
  localparam logic [7:0] AXI_LEN   = 8'h00;
  localparam logic [2:0] AXI_SIZE  = 3'b010;
  localparam logic [1:0] AXI_BURST = 2'b01;

endpackage

// File: rtl/ysyx_24110006_arb_pick.sv
// Two-request picker for the AXI arbiter, one-hot winner out.
// ARB_ROUND_ROBIN_EN selects round-robin, else fixed M1 > M0.
module ysyx_24110006_arb_pick
  import ysyx_24110006_arb_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic [1:0] i_grant,
  output logic [1:0] o_win
);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_m1;

  // Tie pointer: favour whoever was not served last
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rr_m1 <= 1'b1;
    end else if (i_done) begin
      rr_m1 <= i_grant[0] & ~i_grant[1];
    end
  end

  // Round-robin winner selection
  always_comb begin
    o_win = GNT_NONE;
    unique case (1'b1)
      (i_req == 2'b11): o_win = rr_m1 ? GNT_M1 : GNT_M0;
      (i_req == 2'b10): o_win = GNT_M1;
      (i_req == 2'b01): o_win = GNT_M0;
      default:          o_win = GNT_NONE;
    endcase
  end
`else
  logic unused_pick;
  assign unused_pick = ^{i_clock, i_reset, i_done, i_grant};

  // Fixed priority: LSU ahead of IFU
  always_comb begin
    o_win = GNT_NONE;
    unique case (1'b1)
      i_req[1]:                     o_win = GNT_M1;
      (i_req == 2'b01):             o_win = GNT_M0;
      default:                      o_win = GNT_NONE;
    endcase
  end
`endif

endmodule

// File: rtl/ysyx_24110006_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI arbiter.
// Optional ARB_ROUND_ROBIN_EN turns on round-robin arbitration.
module ysyx_24110006_axi_arbiter
  import ysyx_24110006_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_m0_arvalid,
  output logic                o_m0_arready,
  input  logic [ADDR_W-1:0]   i_m0_araddr,
  output logic                o_m0_rvalid,
  input  logic                i_m0_rready,
  output logic [DATA_W-1:0]   o_m0_rdata,
  output logic [1:0]          o_m0_rresp,
  input  logic                i_m1_arvalid,
  output logic                o_m1_arready,
  input  logic [ADDR_W-1:0]   i_m1_araddr,
  output logic                o_m1_rvalid,
  input  logic                i_m1_rready,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic [1:0]          o_m1_rresp,
  input  logic                i_m1_awvalid,
  output logic                o_m1_awready,
  input  logic [ADDR_W-1:0]   i_m1_awaddr,
  input  logic                i_m1_wvalid,
  output logic                o_m1_wready,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_wstrb,
  output logic                o_m1_bvalid,
  input  logic                i_m1_bready,
  output logic [1:0]          o_m1_bresp,
  output logic                o_s_arvalid,
  input  logic                i_s_arready,
  output logic [ADDR_W-1:0]   o_s_araddr,
  output logic [AXI_ID_W-1:0] o_s_arid,
  output logic [7:0]          o_s_arlen,
  output logic [2:0]          o_s_arsize,
  output logic [1:0]          o_s_arburst,
  input  logic                i_s_rvalid,
  output logic                o_s_rready,
  input  logic [DATA_W-1:0]   i_s_rdata,
  input  logic [1:0]          i_s_rresp,
  output logic                o_s_awvalid,
  input  logic                i_s_awready,
  output logic [ADDR_W-1:0]   o_s_awaddr,
  output logic [AXI_ID_W-1:0] o_s_awid,
  output logic [7:0]          o_s_awlen,
  output logic [2:0]          o_s_awsize,
  output logic [1:0]          o_s_awburst,
  output logic                o_s_wvalid,
  input  logic                i_s_wready,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  output logic                o_s_wlast,
  input  logic                i_s_bvalid,
  output logic                o_s_bready,
  input  logic [1:0]          i_s_bresp,
  output logic [1:0]          o_grant
);

  arb_state_e state_q;
  logic       ar_done;
  logic       aw_done;
  logic       w_done;
  logic [1:0] req;
  logic [1:0] win;
  logic       s_ar_hs;
  logic       s_aw_hs;
  logic       s_w_hs;
  logic       r_fin;
  logic       b_fin;
  logic       fin;

  assign o_s_arid    = '0;
  assign o_s_arlen   = AXI_LEN;
  assign o_s_arsize  = AXI_SIZE;
  assign o_s_arburst = AXI_BURST;
  assign o_s_awid    = '0;
  assign o_s_awlen   = AXI_LEN;
  assign o_s_awsize  = AXI_SIZE;
  assign o_s_awburst = AXI_BURST;
  assign o_s_wlast   = 1'b1;

  assign req = {i_m1_arvalid | i_m1_awvalid, i_m0_arvalid};

  assign s_ar_hs = o_s_arvalid & i_s_arready;
  assign s_aw_hs = o_s_awvalid & i_s_awready;
  assign s_w_hs  = o_s_wvalid & i_s_wready;

  assign r_fin = i_s_rvalid & o_s_rready &
                 ((state_q == ST_RD0) | (state_q == ST_RD1));
  assign b_fin = (state_q == ST_WR1) & i_s_bvalid & i_m1_bready;
  assign fin   = r_fin | b_fin;

  ysyx_24110006_arb_pick u_pick (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_req   (req),
    .i_done  (fin),
    .i_grant (o_grant),
    .o_win   (win)
  );

  // Ownership FSM with per-channel done flags and registered grant
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      o_grant <= GNT_NONE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win == GNT_M1) begin
            state_q <= i_m1_awvalid ? ST_WR1 : ST_RD1;
            o_grant <= GNT_M1;
          end else if (win == GNT_M0) begin
            state_q <= ST_RD0;
            o_grant <= GNT_M0;
          end
        end
        ST_RD0, ST_RD1: begin
          if (s_ar_hs) ar_done <= 1'b1;
          if (r_fin) begin
            state_q <= ST_IDLE;
            o_grant <= GNT_NONE;
            ar_done <= 1'b0;
          end
        end
        ST_WR1: begin
          if (s_aw_hs) aw_done <= 1'b1;
          if (s_w_hs)  w_done  <= 1'b1;
          if (b_fin) begin
            state_q <= ST_IDLE;
            o_grant <= GNT_NONE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          o_grant <= GNT_NONE;
        end
      endcase
    end
  end

  // Channel routing muxes selected by the owner state
  always_comb begin
    o_m0_arready = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m0_rdata   = '0;
    o_m0_rresp   = '0;
    o_m1_arready = 1'b0;
    o_m1_rvalid  = 1'b0;
    o_m1_rdata   = '0;
    o_m1_rresp   = '0;
    o_m1_awready = 1'b0;
    o_m1_wready  = 1'b0;
    o_m1_bvalid  = 1'b0;
    o_m1_bresp   = '0;
    o_s_arvalid  = 1'b0;
    o_s_araddr   = '0;
    o_s_rready   = 1'b0;
    o_s_awvalid  = 1'b0;
    o_s_awaddr   = '0;
    o_s_wvalid   = 1'b0;
    o_s_wdata    = '0;
    o_s_wstrb    = '0;
    o_s_bready   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_s_rready = 1'b1;
        o_s_bready = 1'b1;
      end
      ST_RD0: begin
        o_s_arvalid  = i_m0_arvalid & ~ar_done;
        o_s_araddr   = i_m0_araddr;
        o_m0_arready = i_s_arready & ~ar_done;
        o_m0_rvalid  = i_s_rvalid;
        o_m0_rdata   = i_s_rdata;
        o_m0_rresp   = i_s_rresp;
        o_s_rready   = i_m0_rready;
      end
      ST_RD1: begin
        o_s_arvalid  = i_m1_arvalid & ~ar_done;
        o_s_araddr   = i_m1_araddr;
        o_m1_arready = i_s_arready & ~ar_done;
        o_m1_rvalid  = i_s_rvalid;
        o_m1_rdata   = i_s_rdata;
        o_m1_rresp   = i_s_rresp;
        o_s_rready   = i_m1_rready;
      end
      ST_WR1: begin
        o_s_awvalid  = i_m1_awvalid & ~aw_done;
        o_s_awaddr   = i_m1_awaddr;
        o_m1_awready = i_s_awready & ~aw_done;
        o_s_wvalid   = i_m1_wvalid & ~w_done;
        o_s_wdata    = i_m1_wdata;
        o_s_wstrb    = i_m1_wstrb;
        o_m1_wready  = i_s_wready & ~w_done;
        o_m1_bvalid  = i_s_bvalid;
        o_m1_bresp   = i_s_bresp;
        o_s_bready   = i_m1_bready;
      end
      default: begin
        o_s_rready = 1'b0;
      end
    endcase
  end

endmodule
